// File: rtl/spe_clocked_core_if.sv
// spe_clocked_core_if: flit input and spike output valid/ready channels of the spike processing element.
interface spe_clocked_core_if #(
   parameter int PKT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [PKT_W-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [PKT_W-1:0] out_data;
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/spe_clocked_core.sv
// spe_clocked_core: clocked integrate-and-fire core; PSUM flits accumulate, FIRE scans and emits a spike bitmap.
// Define SPE_LEAK_EN to halve (>> LEAK_SHIFT) non-spiking potentials on every scan.
module spe_clocked_core #(
   parameter int                  ADDR_W         = 4,
   parameter int                  OP_W           = 4,
   parameter int                  DATA_W         = 24,
   parameter int                  NUM_NEURONS    = 16,
   parameter int                  POT_W          = 16,
   parameter logic [ADDR_W-1:0]   MY_ADDR        = 4'h0,
   parameter logic [ADDR_W-1:0]   DEST_DEFAULT   = 4'h0,
   parameter logic [POT_W-1:0]    THRESH_DEFAULT = 16'd64,
   parameter int                  LEAK_SHIFT     = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   spe_clocked_core_if.slave  bus,
   output logic               busy,
   output logic               err
);
   localparam int PKT_W = ADDR_W + OP_W + DATA_W;
   localparam int IDX_W = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
`ifdef SPE_LEAK_EN
   localparam int SHIFT = LEAK_SHIFT;
`else
   localparam int SHIFT = 0;
`endif
   localparam logic [OP_W-1:0] OP_CFG   = OP_W'(1);
   localparam logic [OP_W-1:0] OP_PSUM  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_FIRE  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SPIKE = OP_W'(4);

   typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;

   state_t                 r_state;
   logic [POT_W-1:0]       r_pot [NUM_NEURONS];
   logic [POT_W-1:0]       r_thr;
   logic [ADDR_W-1:0]      r_dest;
   logic [IDX_W-1:0]       r_idx;
   logic [NUM_NEURONS-1:0] r_bitmap;
   logic                   r_in_ready;
   logic                   r_out_valid;
   logic [PKT_W-1:0]       r_out_data;
   logic                   r_err;
   logic                   r_busy;

   logic [ADDR_W-1:0] w_dest;
   logic [OP_W-1:0]   w_op;
   logic [DATA_W-1:0] w_pay;
   logic [7:0]        w_nidx;
   logic [IDX_W-1:0]  w_slot;
   logic [POT_W-1:0]  w_val;
   logic [POT_W:0]    w_sum;
   logic [POT_W-1:0]  w_cur;
   logic              w_fire;
   logic              w_take;
   logic              w_ok;
   logic              w_last;

   assign w_dest = bus.in_data[PKT_W-1 -: ADDR_W];
   assign w_op   = bus.in_data[DATA_W +: OP_W];
   assign w_pay  = bus.in_data[DATA_W-1:0];
   assign w_nidx = w_pay[23:16];
   assign w_slot = IDX_W'(w_nidx);
   assign w_val  = POT_W'(w_pay[15:0]);
   assign w_sum  = {1'b0, r_pot[w_slot]} + {1'b0, w_val};
   assign w_cur  = r_pot[r_idx];
   assign w_fire = w_cur >= r_thr;
   assign w_take = bus.in_valid && r_in_ready;
   assign w_last = r_idx == IDX_W'(NUM_NEURONS - 1);
   // Out-of-range neuron indices count as malformed flits, same as foreign dest or unknown opcode.
   assign w_ok   = (w_dest == MY_ADDR) &&
                   (w_op == OP_CFG || w_op == OP_FIRE ||
                    (w_op == OP_PSUM && 32'(w_nidx) < NUM_NEURONS));

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign busy          = r_busy;
   assign err           = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         for (int k = 0; k < NUM_NEURONS; k++) r_pot[k] <= '0;
         r_thr       <= THRESH_DEFAULT;
         r_dest      <= DEST_DEFAULT;
         r_idx       <= '0;
         r_bitmap    <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_in_ready <= 1'b1;
               if (w_take) begin
                  if (!w_ok) r_err <= 1'b1;
                  else if (w_op == OP_CFG) begin
                     r_thr  <= w_val;
                     r_dest <= ADDR_W'(w_pay[23:20]);
                  end else if (w_op == OP_PSUM)
                     r_pot[w_slot] <= w_sum[POT_W] ? '1 : w_sum[POT_W-1:0];
                  else begin
                     r_state    <= SCAN;
                     r_idx      <= '0;
                     r_bitmap   <= '0;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b1;
                  end
               end
            end
            SCAN: begin
               r_bitmap[r_idx] <= w_fire;
               r_pot[r_idx]    <= w_fire ? '0 : w_cur >> SHIFT;
               r_idx           <= w_last ? r_idx : r_idx + 1'b1;
               r_state         <= w_last ? SEND : SCAN;
            end
            SEND: begin
               // Bitmap settles at the SCAN->SEND edge; the flit is presented one edge later.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= {r_dest, OP_SPIKE, DATA_W'(r_bitmap)};
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spe_clocked_core.sv
// tb_spe_clocked_core: directed flits with a queue of expected spike flits checked by an output monitor.
module tb_spe_clocked_core;
   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic err;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] exp_q[$];
`ifdef SPE_LEAK_EN
   localparam logic [31:0] CFG_THR5 = 32'h01000002;
`else
   localparam logic [31:0] CFG_THR5 = 32'h0100000A;
`endif

   spe_clocked_core_if #(.PKT_W(32)) bus ();

   spe_clocked_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_flit actual=%h expected=none", bus.out_data);
         end else chk("spike_flit", bus.out_data, exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] f);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = f;
      while (!bus.in_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk("in_ready_after_edge", {31'd0, bus.in_ready}, 32'd1);
      exp_q.push_back(32'h04000000);
      send(32'h03000000);
      drain();
      send(32'h02030028);
      send(32'h02030028);
      send(32'h0205000A);
      exp_q.push_back(32'h04000008);
      send(32'h03000000);
      chk("scan_busy", {31'd0, busy}, 32'd1);
      chk("scan_in_ready", {31'd0, bus.in_ready}, 32'd0);
      cnt = 0;
      while (!bus.out_valid && cnt < 100) begin
         tick();
         cnt++;
      end
      chk("fire_latency", 32'(cnt), 32'd17);
      drain();
      exp_q.push_back(32'h04000000);
      send(32'h03000000);
      send(CFG_THR5);
      exp_q.push_back(32'h04000020);
      send(32'h03000000);
      drain();
      send(32'h01700020);
      send(32'h02000020);
      exp_q.push_back(32'h74000001);
      send(32'h03000000);
      send(32'h0170FFFF);
      send(32'h0201FFFF);
      send(32'h0201FFFF);
      exp_q.push_back(32'h74000002);
      send(32'h03000000);
      drain();
      chk("err_clean", {31'd0, err}, 32'd0);
      send(32'h52030028);
      tick();
      chk("err_bad_dest", {31'd0, err}, 32'd1);
      send(32'h09000000);
      send(32'h02140028);
      send(32'h53000000);
      send(32'h01700001);
      exp_q.push_back(32'h74000000);
      send(32'h03000000);
      send(32'h01700000);
      exp_q.push_back(32'h7400FFFF);
      send(32'h03000000);
      drain();
      bus.out_ready = 1'b0;
      exp_q.push_back(32'h7400FFFF);
      send(32'h03000000);
      cnt = 0;
      while (!bus.out_valid && cnt < 100) begin
         tick();
         cnt++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("hold_data", bus.out_data, 32'h7400FFFF);
         chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      chk("post_send_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("post_send_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("err_sticky", {31'd0, err}, 32'd1);
      send(32'h01700040);
      send(32'h02040064);
      send(32'h03000000);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("abort_err", {31'd0, err}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
      exp_q.push_back(32'h04000000);
      send(32'h03000000);
      drain();
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spe_clocked_core.md
Name: spe_clocked_core

Overview:
- Clocked, parametrised spike processing element core. Successor to the CSP-channel SPE.
- Takes flat NoC flits on a valid/ready input. Accumulates partial sums into per-neuron membrane potentials.
- On a FIRE command, thresholds every neuron and emits one spike-bitmap flit on a valid/ready output.
- Sits between the router's local port depacketize side and packetize side; the depacketizer/packetizer functions are folded in.

Parameters:
- ADDR_W, 4, dest-address field width
- OP_W, 4, opcode field width
- DATA_W, 24, payload width; PKT_W = ADDR_W+OP_W+DATA_W
- NUM_NEURONS, 16, neuron count; legal range 1..DATA_W
- POT_W, 16, membrane potential width (unsigned)
- MY_ADDR, 4'h0, this node's address
- DEST_DEFAULT, 4'h0, reset value of the output destination register
- THRESH_DEFAULT, 16'd64, reset value of the threshold register
- LEAK_SHIFT, 1, decay shift amount; used only with LEAK_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input flit valid
- in_ready  out  1  core can accept a flit
- in_data  in  PKT_W  {dest, opcode, payload}, dest in the MSBs
- out_valid  out  1  output flit valid
- out_ready  in  1  downstream accepts the flit
- out_data  out  PKT_W  {out_dest, OP_SPIKE, bitmap}
- busy  out  1  state != IDLE
- err  out  1  sticky drop flag; cleared only by reset

Behaviour:
- Reset (async, rst_n=0), all registers cleared immediately:
  - potentials = 0, threshold = THRESH_DEFAULT, out_dest = DEST_DEFAULT
  - state = IDLE, out_valid = 0, out_data = 0, err = 0, busy = 0, in_ready = 0
  - in_ready rises on the first clk edge after deassertion.
  - Reset mid-SCAN or mid-SEND aborts: no flit is emitted and partial bitmaps are discarded.
- Opcodes: CFG = 4'h1, PSUM = 4'h2, FIRE = 4'h3, SPIKE = 4'h4 (output only).
- Handshake:
  - A transfer occurs on the rising edge where valid && ready.
  - in_ready = 1 only in IDLE.
  - out_data is stable while out_valid = 1 and !out_ready; out_valid never drops without a transfer.
- IDLE, accepted flit:
  - dest != MY_ADDR: dropped, err set.
  - Unknown opcode: dropped, err set.
  - CFG: threshold <= payload[15:0]; out_dest <= payload[23:20]. Effective next cycle.
  - PSUM:
    - idx = payload[23:16], val = payload[15:0].
    - pot[idx] <= min(pot[idx] + val, 2^POT_W - 1), i.e. saturating; no wrap.
    - Stays in IDLE, so back-to-back PSUMs run at 1 flit/cycle.
    - Same index on consecutive cycles accumulates correctly; the write is at the edge, so there is no hazard.
    - idx >= NUM_NEURONS: dropped, err set.
  - FIRE: state -> SCAN, scan index i = 0, bitmap = 0.
- SCAN: one neuron per cycle, i = 0..NUM_NEURONS-1.
  - pot[i] >= threshold: bitmap[i] = 1, pot[i] <= 0.
  - Otherwise pot[i] is unchanged.
  - threshold = 0 makes every neuron spike.
  - After the last neuron: state -> SEND.
- SEND:
  - out_valid = 1; out_data = {out_dest, 4'h4, bitmap zero-extended to DATA_W}.
  - An all-zero bitmap is still sent.
  - On out_ready: out_valid = 0 next cycle, state -> IDLE.
- Latency: FIRE accepted at edge T gives out_valid = 1 after edge T+NUM_NEURONS+1. Next in_ready = 1 on the cycle after the output transfer.
- in_valid held during SCAN/SEND is not consumed; the flit is taken once IDLE returns.

Optional Feature:
- Macro: SPE_LEAK_EN.
- Defined: during SCAN, a non-spiking neuron's pot[i] <= pot[i] >> LEAK_SHIFT (leaky integrate-and-fire). Spiking neurons still reset to 0.
- Undefined: non-spiking potentials are retained unchanged. LEAK_SHIFT is unused.

Test Plan:
- Reset then idle: out_valid = 0, err = 0, in_ready = 1 one edge after rst_n rises. FIRE -> SPIKE flit {0x0, 0x4, 0x000000}.
- PSUM idx 3 val 40 twice back-to-back, PSUM idx 5 val 10, then FIRE -> bitmap 0x000008. out_valid asserts 17 cycles after the FIRE accept. A second FIRE -> bitmap 0 (idx 3 cleared); idx 5 still holds 10 without leak, 5 with SPE_LEAK_EN.
- CFG payload 0x700020 (dest 7, thr 32), PSUM idx 0 val 32, FIRE -> out_data {0x7, 0x4, 0x000001}.
- PSUM idx 1 val 0xFFFF twice -> pot saturates at 0xFFFF, not 0xFFFE. FIRE -> bit 1 set.
- Error drops: flit with dest 0x5, opcode 0x9, or PSUM idx 20 -> err = 1, potentials unchanged, no output.
- out_ready held low 10 cycles during SEND -> out_data stable, in_ready = 0. Asserting rst_n = 0 mid-SCAN -> out_valid = 0 immediately and potentials = 0.
